// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
//   Upstream instruction source for the cpu. Holds a small writable program
//   memory and hands the cpu one word at a time: present the word on cpu_in
//   with a load strobe, then a start strobe s. It then waits for the cpu's
//   w flag to fall (cpu busy) and rise again (cpu idle) before moving to the
//   next address. A run ends on the HALT word, after the last address, or
//   when the watchdog expires while waiting on w.
//
// Optional feature (compile-time macro STEP_MODE_EN):
//   Adds a 'step' input. The FSM then holds in NEXT until a rising edge on
//   step, and advances exactly one word per pulse.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   go         in   1   start a run from address 0 (sampled in IDLE only)
//   prog_we    in   1   program-memory write strobe (ignored while busy)
//   prog_addr  in   AW  write address
//   prog_data  in   16  write data
//   w          in   1   cpu waiting flag (1 = cpu idle, ready for s)
//   step       in   1   single-step advance (only with STEP_MODE_EN)
//   cpu_in     out  16  instruction to the cpu's in port
//   load       out  1   one-cycle load strobe to the cpu instruction register
//   s          out  1   one-cycle start strobe to the cpu
//   pc         out  AW  address of the current word
//   busy       out  1   1 while a run is in progress
//   done       out  1   run finished normally; held until go=0 or reset
//   err        out  1   watchdog fired; held until reset
// -----------------------------------------------------------------------------
module instr_feeder #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [15:0] HALT_WORD = 16'hE000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          w,
`ifdef STEP_MODE_EN
  input  logic          step,
`endif
  output logic [15:0]   cpu_in,
  output logic          load,
  output logic          s,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [AW-1:0]  PC_LAST  = AW'(DEPTH - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_NEXT    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  logic [2:0]     state;
  logic [15:0]    mem [DEPTH];
  logic [15:0]    cpu_in_q;
  logic [WDW-1:0] wd;
  logic [15:0]    cur_word;
  logic           is_halt;
  logic           issue;
  logic           wd_expired;
  logic           advance;

  // ---------------------------------------------------------------------------
  // Program memory
  // NOTE: the storage array has no reset branch on purpose; a reset must not
  // wipe a loaded program, and leaving it out lets the array map onto plain
  // storage instead of a bank of resettable flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Combinational read: a write committed together with go in IDLE is
  // already visible when LOAD reads address 0 on the next cycle.
  assign cur_word = mem[pc];
  assign is_halt  = (cur_word == HALT_WORD);

  // ---------------------------------------------------------------------------
  // Step edge detect (one advance per step pulse)
  // ---------------------------------------------------------------------------
`ifdef STEP_MODE_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign advance = step && !step_q;
`else
  assign advance = 1'b1;
`endif

  assign wd_expired = (wd == WD_LAST);

  // ---------------------------------------------------------------------------
  // Sequencer
  // NOTE: every register here is updated with <= so all branches see the
  // values from before the edge; mixing in blocking assignments would make
  // the result depend on statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      cpu_in_q <= '0;
      wd       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            pc    <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (is_halt) begin
            state <= ST_DONE;
          end else begin
            cpu_in_q <= cur_word;
            state    <= ST_START;
          end
        end
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!w) begin
            wd    <= '0;
            state <= ST_WAIT_HI;
          end else if (wd_expired) begin
            state <= ST_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (w) begin
            state <= ST_NEXT;
          end else if (wd_expired) begin
            state <= ST_ERR;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_NEXT: begin
          if (advance) begin
            if (pc == PC_LAST) begin
              state <= ST_DONE;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (!go) begin
            state <= ST_IDLE;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // Strobes are gated with reset so an abort removes them in the same cycle
  // rather than one edge later.
  // ---------------------------------------------------------------------------
  assign issue  = (state == ST_LOAD) && !is_halt && !reset;
  assign load   = issue;
  assign s      = (state == ST_START) && !reset;
  // The word is shown during its load cycle and then held from the register
  // until the next load.
  assign cpu_in = issue ? cur_word : cpu_in_q;
  assign busy   = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done   = (state == ST_DONE);
  assign err    = (state == ST_ERR);

endmodule
